log_collector: RTL and testbench

Multi-channel hardware event logger: N_CH independent sources present (severity, message-id) events, filtered against a runtime severity threshold, arbitrated round-robin, optionally timestamped, and buffered in a DEPTH-entry FIFO drained by a single valid/ready consumer. Sits between instrumented RTL blocks and a trace/debug sink, as the parametrised multi-source generation of the team's logger facility.

---
 rtl/log_pkg.sv | 6 +
 rtl/log_fifo.sv | 45 ++++
 rtl/log_collector.sv | 104 ++++++++++
 tb/tb_log_collector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// log_pkg: shared severity encoding and counter widths for the log collector
package log_pkg;
  localparam int SEV_W = 2;
  localparam int FILT_CNT_W = 16;
  typedef enum logic [SEV_W-1:0] {SEV_INFO, SEV_WARNING, SEV_ERROR, SEV_FATAL} sev_e;
endpackage

// File: rtl/log_fifo.sv
// log_fifo: sync FIFO with registered head (push/din in, pop/dout out, full/empty/fill status)
module log_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int PW = AW + 1,
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [WIDTH-1:0]  din,
  input  logic              pop,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [FILL_W-1:0] fill
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] rd_nxt;
  logic do_push, do_pop;
  assign fill = wr_ptr - rd_ptr;
  assign full = fill == FILL_W'(DEPTH);
  assign empty = fill == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rd_nxt = rd_ptr[AW-1:0] + AW'(1);
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  // dout always mirrors the head entry; it is loaded from din when the pushed
  // word becomes the head, otherwise from the entry behind the one popped
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      dout <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      if (do_push && (empty || (do_pop && fill == FILL_W'(1)))) dout <= din;
      else if (do_pop && fill != FILL_W'(1)) dout <= mem[rd_nxt];
    end
  end
endmodule

// File: rtl/log_collector.sv
// log_collector: N_CH-source event logger with severity filter, round-robin arbiter and FIFO.
// Ports: thresh/in_valid/in_sev/in_id in, in_ready out per channel; out_valid/out_ready
// handshake with out_ch/out_sev/out_id (+out_ts) head fields; fill, filt_cnt, fatal status.
// Define LOG_COLLECTOR_TIMESTAMP_EN to add the free-running timestamp and out_ts port.
module log_collector
  import log_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int ID_W = 12,
  parameter int DEPTH = 16,
  parameter int TS_W = 32,
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int FILL_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEV_W-1:0]      thresh,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [SEV_W*N_CH-1:0] in_sev,
  input  logic [ID_W*N_CH-1:0]  in_id,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH_W-1:0]       out_ch,
  output logic [SEV_W-1:0]      out_sev,
  output logic [ID_W-1:0]       out_id,
  output logic [FILL_W-1:0]     fill,
  output logic [FILT_CNT_W-1:0] filt_cnt,
  output logic                  fatal
`ifdef LOG_COLLECTOR_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]       out_ts
`endif
);
`ifdef LOG_COLLECTOR_TIMESTAMP_EN
  localparam int TS_BITS = TS_W;
`else
  localparam int TS_BITS = 0 * TS_W;
`endif
  localparam int E_W = TS_BITS + CH_W + SEV_W + ID_W;
  logic [N_CH-1:0] pass, filt, gnt;
  logic [CH_W-1:0] p, gnt_ch;
  logic [SEV_W-1:0] gnt_sev;
  logic [ID_W-1:0] gnt_id;
  logic [FILT_CNT_W:0] nfilt, fsum;
  logic [E_W-1:0] din, dout;
  logic push, pop, full, empty;
  always_comb begin
    pass = '0;
    filt = '0;
    nfilt = '0;
    for (int k = 0; k < N_CH; k++) begin
      pass[k] = in_valid[k] && (in_sev[SEV_W*k +: SEV_W] >= thresh);
      filt[k] = in_valid[k] && (in_sev[SEV_W*k +: SEV_W] < thresh);
      nfilt = nfilt + {{FILT_CNT_W{1'b0}}, filt[k]};
    end
  end
  // scanning from the far end back toward p leaves the first passing channel at or after p
  always_comb begin
    gnt_ch = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (pass[(int'(p) + i) % N_CH]) gnt_ch = CH_W'((int'(p) + i) % N_CH);
    gnt = (|pass && !full && !rst) ? N_CH'(1) << gnt_ch : '0;
  end
  assign push = |gnt;
  assign in_ready = rst ? '0 : (filt | gnt);
  assign gnt_sev = in_sev[SEV_W*int'(gnt_ch) +: SEV_W];
  assign gnt_id = in_id[ID_W*int'(gnt_ch) +: ID_W];
  assign out_valid = !empty;
  assign pop = out_valid && out_ready;
  assign fsum = {1'b0, filt_cnt} + nfilt;
`ifdef LOG_COLLECTOR_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  always_ff @(posedge clk)
    ts <= rst ? '0 : ts + TS_W'(1);
  assign din = {ts, gnt_ch, gnt_sev, gnt_id};
  assign {out_ts, out_ch, out_sev, out_id} = dout;
`else
  assign din = {gnt_ch, gnt_sev, gnt_id};
  assign {out_ch, out_sev, out_id} = dout;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      p <= '0;
      filt_cnt <= '0;
      fatal <= 1'b0;
    end else begin
      if (push) p <= (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
      filt_cnt <= fsum[FILT_CNT_W] ? '1 : fsum[FILT_CNT_W-1:0];
      if (push && gnt_sev == SEV_FATAL) fatal <= 1'b1;
    end
  end
  log_fifo #(.WIDTH(E_W), .DEPTH(DEPTH)) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (din),
    .pop  (pop),
    .dout (dout),
    .full (full),
    .empty(empty),
    .fill (fill)
  );
endmodule

// File: tb/tb_log_collector.sv
// tb_log_collector: directed self-checking bench for log_collector (N_CH=4, DEPTH=16)
module tb_log_collector;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] thresh;
  logic [3:0] in_valid;
  logic [7:0] in_sev;
  logic [47:0] in_id;
  logic [3:0] in_ready;
  logic out_valid, out_ready;
  logic [1:0] out_ch, out_sev;
  logic [11:0] out_id;
  logic [4:0] fill;
  logic [15:0] filt_cnt;
  logic fatal;
`ifdef LOG_COLLECTOR_TIMESTAMP_EN
  logic [3:0] out_ts;
`endif
  int checks = 0;
  int errors = 0;
  int p_m = 0;
  int exp_filt = 0;
  logic [13:0] exp_q[$];
  always #5 clk = ~clk;
  log_collector #(.N_CH(4), .ID_W(12), .DEPTH(16), .TS_W(4)) dut (
    .clk(clk), .rst(rst), .thresh(thresh), .in_valid(in_valid), .in_sev(in_sev),
    .in_id(in_id), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .out_sev(out_sev), .out_id(out_id), .fill(fill),
    .filt_cnt(filt_cnt), .fatal(fatal)
`ifdef LOG_COLLECTOR_TIMESTAMP_EN
    , .out_ts(out_ts)
`endif
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_ids(input int c);
    for (int k = 0; k < 4; k++) in_id[12*k +: 12] = 12'(c * 16 + k);
  endtask
  function automatic int rr_pick(input int pp, input logic [3:0] ps);
    for (int i = 0; i < 4; i++) if (ps[(pp + i) % 4]) return (pp + i) % 4;
    return -1;
  endfunction
  task automatic test_reset;
    rst = 1'b1; thresh = 2'd0; in_valid = 4'hF; in_sev = 8'hFF; in_id = '0; out_ready = 1'b0;
    tick;
    tick;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b expected 0000", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", out_valid); end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL reset_fill got %0d expected 0", fill); end
    checks++; if (filt_cnt !== 16'd0) begin errors++; $display("FAIL reset_filt_cnt got %0d expected 0", filt_cnt); end
    checks++; if (fatal !== 1'b0) begin errors++; $display("FAIL reset_fatal got %b expected 0", fatal); end
    checks++; if ({out_ch, out_sev, out_id} !== 16'd0) begin errors++; $display("FAIL reset_head got %h expected 0", {out_ch, out_sev, out_id}); end
    rst = 1'b0; in_valid = 4'h0;
  endtask
  task automatic test_round_robin;
    thresh = 2'd0; in_valid = 4'hF; in_sev = 8'h00; in_id = 48'h103102101100; out_ready = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_first_valid got %b expected 0", out_valid); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (in_ready !== 4'(1 << (i % 4))) begin errors++; $display("FAIL rr_ready cyc %0d got %b expected %b", i, in_ready, 4'(1 << (i % 4))); end
      tick;
      if (i == 5) in_valid = 4'h0;
      checks++; if (out_valid !== 1'b1 || out_ch !== 2'(i % 4) || out_id !== 12'(256 + i % 4)) begin errors++; $display("FAIL rr_head cyc %0d got v=%b ch=%0d id=%h expected v=1 ch=%0d id=%h", i, out_valid, out_ch, out_id, i % 4, 12'(256 + i % 4)); end
      checks++; if (fill !== 5'd1) begin errors++; $display("FAIL rr_fill cyc %0d got %0d expected 1", i, fill); end
      #1;
    end
    tick;
    checks++; if (fill !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL rr_drain got fill=%0d v=%b expected fill=0 v=0", fill, out_valid); end
    p_m = 2;
  endtask
  task automatic test_filter;
    thresh = 2'd2; in_valid = 4'b0011; in_sev = 8'b00_00_11_01; in_id = 48'h103102101100; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0011) begin errors++; $display("FAIL filt_ready got %b expected 0011", in_ready); end
    checks++; if (fatal !== 1'b0) begin errors++; $display("FAIL filt_fatal_before got %b expected 0", fatal); end
    tick;
    in_valid = 4'h0;
    exp_filt = 1;
    checks++; if (filt_cnt !== 16'd1) begin errors++; $display("FAIL filt_cnt got %0d expected 1", filt_cnt); end
    checks++; if (fatal !== 1'b1) begin errors++; $display("FAIL filt_fatal got %b expected 1", fatal); end
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_sev !== 2'd3 || out_id !== 12'h101) begin errors++; $display("FAIL filt_head got v=%b ch=%0d sev=%0d id=%h expected v=1 ch=1 sev=3 id=101", out_valid, out_ch, out_sev, out_id); end
    tick;
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL filt_fill got %0d expected 0", fill); end
    p_m = 2;
  endtask
  task automatic test_full;
    int pick;
    thresh = 2'd1; out_ready = 1'b0; in_valid = 4'hF; in_sev = 8'h55;
    for (int c = 0; c < 16; c++) begin
      set_ids(c);
      #1;
      pick = rr_pick(p_m, 4'hF);
      checks++; if (in_ready !== 4'(1 << pick)) begin errors++; $display("FAIL full_ready cyc %0d got %b expected %b", c, in_ready, 4'(1 << pick)); end
      exp_q.push_back({2'(pick), 12'(c * 16 + pick)});
      p_m = (pick + 1) % 4;
      tick;
    end
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL full_fill got %0d expected 16", fill); end
    in_sev = 8'h54;
    set_ids(16);
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL full_filtered_ready got %b expected 0001", in_ready); end
    exp_filt++;
    tick;
    checks++; if (filt_cnt !== 16'(exp_filt) || fill !== 5'd16) begin errors++; $display("FAIL full_hold got filt=%0d fill=%0d expected filt=%0d fill=16", filt_cnt, fill, exp_filt); end
    in_sev = 8'h55; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL full_pop_ready got %b expected 0000", in_ready); end
    checks++; if (out_valid !== 1'b1 || {out_ch, out_id} !== exp_q[0]) begin errors++; $display("FAIL full_pop_head got v=%b %h expected v=1 %h", out_valid, {out_ch, out_id}, exp_q[0]); end
    void'(exp_q.pop_front());
    tick;
    checks++; if (fill !== 5'd15) begin errors++; $display("FAIL full_after_pop got %0d expected 15", fill); end
    out_ready = 1'b0;
    set_ids(17);
    #1;
    checks++; if (in_ready !== 4'(1 << p_m)) begin errors++; $display("FAIL full_refill_ready got %b expected %b", in_ready, 4'(1 << p_m)); end
    exp_q.push_back({2'(p_m), 12'(17 * 16 + p_m)});
    p_m = (p_m + 1) % 4;
    tick;
    checks++; if (fill !== 5'd16) begin errors++; $display("FAIL full_refill got %0d expected 16", fill); end
    in_valid = 4'h0; out_ready = 1'b1;
    for (int n = 0; n < 40 && exp_q.size() > 0; n++) begin
      checks++; if (out_valid !== 1'b1 || {out_ch, out_id} !== exp_q[0]) begin errors++; $display("FAIL drain_entry %0d got v=%b %h expected v=1 %h", n, out_valid, {out_ch, out_id}, exp_q[0]); end
      void'(exp_q.pop_front());
      tick;
    end
    checks++; if (exp_q.size() != 0 || fill !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL drain_end got left=%0d fill=%0d v=%b expected 0 0 0", exp_q.size(), fill, out_valid); end
  endtask
  task automatic test_storm;
    thresh = 2'd3; in_valid = 4'b0111; in_sev = 8'h00; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0111) begin errors++; $display("FAIL storm_ready got %b expected 0111", in_ready); end
    repeat (21846) tick;
    checks++; if (filt_cnt !== 16'hFFFF) begin errors++; $display("FAIL storm_sat got %h expected ffff", filt_cnt); end
    checks++; if (fill !== 5'd0) begin errors++; $display("FAIL storm_fill got %0d expected 0", fill); end
    in_valid = 4'h0;
  endtask
  task automatic test_reset_mid;
    thresh = 2'd0; out_ready = 1'b0; in_valid = 4'hF; in_sev = 8'hFF; in_id = 48'h103102101100;
    repeat (9) tick;
    checks++; if (fill !== 5'd9 || fatal !== 1'b1) begin errors++; $display("FAIL mid_fill got fill=%0d fatal=%b expected 9 1", fill, fatal); end
    rst = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready got %b expected 0000", in_ready); end
    tick;
    rst = 1'b0; in_sev = 8'h00;
    checks++; if (fill !== 5'd0 || out_valid !== 1'b0 || fatal !== 1'b0 || filt_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_state got fill=%0d v=%b fatal=%b filt=%0d expected 0 0 0 0", fill, out_valid, fatal, filt_cnt); end
    #1;
    checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL mid_resume_ready got %b expected 0001", in_ready); end
    tick;
    in_valid = 4'h0;
    checks++; if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_id !== 12'h100) begin errors++; $display("FAIL mid_resume_head got v=%b ch=%0d id=%h expected 1 0 100", out_valid, out_ch, out_id); end
    tick;
    tick;
  endtask
`ifdef LOG_COLLECTOR_TIMESTAMP_EN
  task automatic test_timestamp;
    rst = 1'b1; in_valid = 4'h0; thresh = 2'd0; in_sev = 8'h00; out_ready = 1'b1;
    tick;
    rst = 1'b0;
    repeat (14) tick;
    in_valid = 4'b0001;
    tick;
    in_valid = 4'h0;
    checks++; if (out_valid !== 1'b1 || out_ts !== 4'd14) begin errors++; $display("FAIL ts_first got v=%b ts=%0d expected 1 14", out_valid, out_ts); end
    tick;
    tick;
    in_valid = 4'b0001;
    tick;
    in_valid = 4'h0;
    checks++; if (out_valid !== 1'b1 || out_ts !== 4'd1) begin errors++; $display("FAIL ts_wrap got v=%b ts=%0d expected 1 1", out_valid, out_ts); end
  endtask
`endif
  initial begin
    test_reset;
    test_round_robin;
    test_filter;
    test_full;
    test_storm;
    test_reset_mid;
`ifdef LOG_COLLECTOR_TIMESTAMP_EN
    test_timestamp;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
